// File: rtl/reorder_buffer_pkg.sv
// Shared widths, entry kinds and payload types for the reorder buffer.
package reorder_buffer_pkg;

   localparam int unsigned ID_W   = 5;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned XLEN   = 32;
   localparam int unsigned KIND_W = 2;

   typedef enum logic [KIND_W-1:0] {
      KIND_REG    = 2'd0,
      KIND_BRANCH = 2'd1,
      KIND_STORE  = 2'd2
   } rob_kind_e;

   typedef struct packed {
      rob_kind_e        kind;
      logic [REG_W-1:0] rd;
      logic [XLEN-1:0]  pred_pc;
      logic [XLEN-1:0]  value;
      logic [XLEN-1:0]  next_pc;
   } rob_entry_t;

   typedef struct packed {
      logic            ready;
      logic [XLEN-1:0] value;
   } rob_lookup_t;

   // A retiring branch whose resolved target differs from the prediction.
   function automatic logic is_mispredict(input rob_entry_t e);
      return (e.kind == KIND_BRANCH) && (e.next_pc != e.pred_pc);
   endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation and retirement, out-of-order
// writeback from two buses, operand forwarding and branch-mispredict flush.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int unsigned ROB_SIZE = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              issue_valid,
   input  logic [KIND_W-1:0] issue_kind,
   input  logic [REG_W-1:0]  issue_rd,
   input  logic [XLEN-1:0]   issue_pred_pc,
   output logic [ID_W-1:0]   dest_to_issuer,
   output logic              is_ro_buffer_full,
   input  logic [ID_W-1:0]   dest_from_rss_bus,
   input  logic [XLEN-1:0]   value_from_rss_bus,
   input  logic [XLEN-1:0]   next_pc_from_rss_bus,
   input  logic [ID_W-1:0]   dest_from_lsb_bus,
   input  logic [XLEN-1:0]   value_from_lsb_bus,
   input  logic [ID_W-1:0]   qj_id,
   output logic              qj_ready,
   output logic [XLEN-1:0]   qj_value,
   input  logic [ID_W-1:0]   qk_id,
   output logic              qk_ready,
   output logic [XLEN-1:0]   qk_value,
   output logic              commit_valid,
   output logic [KIND_W-1:0] commit_kind,
   output logic [REG_W-1:0]  commit_rd,
   output logic [XLEN-1:0]   commit_value,
   output logic [ID_W-1:0]   commit_dest,
   output logic              flush,
   output logic [XLEN-1:0]   flush_pc
);

   localparam int unsigned IDX_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
   localparam int unsigned CNT_W = $clog2(ROB_SIZE + 1);
   localparam logic [ID_W-1:0] MAX_ID = ID_W'(ROB_SIZE);

   logic [ROB_SIZE-1:0] busy;
   logic [ROB_SIZE-1:0] ready;
   rob_entry_t          entry [ROB_SIZE];
   logic [IDX_W-1:0]    head;
   logic [IDX_W-1:0]    tail;
   logic [CNT_W-1:0]    count;
   logic                full;

   rob_entry_t       head_entry;
   logic             do_commit;
   logic             mispredict;
   logic             do_alloc;
   logic [IDX_W-1:0] rss_idx;
   logic [IDX_W-1:0] lsb_idx;
   logic             rss_wr;
   logic             lsb_wr;
   rob_lookup_t      qj_res;
   rob_lookup_t      qk_res;

   function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
      return (p == IDX_W'(ROB_SIZE - 1)) ? '0 : p + IDX_W'(1);
   endfunction

   // Lookup priority: id 0, lsb bus, rss bus, then the stored entry.
   function automatic rob_lookup_t lookup(input logic [ID_W-1:0] id);
      rob_lookup_t      res;
      logic [IDX_W-1:0] idx;
      res = '0;
      idx = IDX_W'(id - ID_W'(1));
      if (id == '0) begin
         res.ready = 1'b1;
      end else if (id == dest_from_lsb_bus) begin
         res = '{ready: 1'b1, value: value_from_lsb_bus};
      end else if (id == dest_from_rss_bus) begin
         res = '{ready: 1'b1, value: value_from_rss_bus};
      end else if (id <= MAX_ID && ready[idx]) begin
         res = '{ready: 1'b1, value: entry[idx].value};
      end
      return res;
   endfunction

   assign full              = (count == CNT_W'(ROB_SIZE));
   assign is_ro_buffer_full = full;
   assign dest_to_issuer    = ID_W'(tail) + ID_W'(1);

   always_comb begin
      head_entry = entry[head];
      do_commit  = rdy && busy[head] && ready[head];
      mispredict = do_commit && is_mispredict(head_entry);
      // No allocation while a flush is being decided or is on the output.
      do_alloc   = rdy && issue_valid && !full && !flush && !mispredict;
      rss_idx    = IDX_W'(dest_from_rss_bus - ID_W'(1));
      lsb_idx    = IDX_W'(dest_from_lsb_bus - ID_W'(1));
      rss_wr     = rdy && !mispredict && (dest_from_rss_bus != '0) &&
                   (dest_from_rss_bus <= MAX_ID) && busy[rss_idx];
      lsb_wr     = rdy && !mispredict && (dest_from_lsb_bus != '0) &&
                   (dest_from_lsb_bus <= MAX_ID) && busy[lsb_idx];
   end

   always_comb begin
      qj_res   = lookup(qj_id);
      qk_res   = lookup(qk_id);
      qj_ready = qj_res.ready;
      qj_value = qj_res.value;
      qk_ready = qk_res.ready;
      qk_value = qk_res.value;
   end

   // Control state and registered retirement outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy         <= '0;
         ready        <= '0;
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         commit_valid <= 1'b0;
         commit_kind  <= '0;
         commit_rd    <= '0;
         commit_value <= '0;
         commit_dest  <= '0;
         flush        <= 1'b0;
         flush_pc     <= '0;
      end else if (rdy) begin
         commit_valid <= do_commit;
         flush        <= mispredict;
         if (do_commit) begin
            commit_kind  <= head_entry.kind;
            commit_rd    <= (head_entry.kind == KIND_REG) ? head_entry.rd : '0;
            commit_value <= head_entry.value;
            commit_dest  <= ID_W'(head) + ID_W'(1);
         end
         if (mispredict) begin
            flush_pc <= head_entry.next_pc;
            busy     <= '0;
            ready    <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
         end else begin
            if (rss_wr) ready[rss_idx] <= 1'b1;
            if (lsb_wr) ready[lsb_idx] <= 1'b1;
            if (do_alloc) begin
               busy[tail]  <= 1'b1;
               ready[tail] <= 1'b0;
               tail        <= ptr_inc(tail);
            end
            if (do_commit) begin
               busy[head]  <= 1'b0;
               ready[head] <= 1'b0;
               head        <= ptr_inc(head);
            end
            count <= count + CNT_W'(do_alloc) - CNT_W'(do_commit);
         end
      end else begin
         commit_valid <= 1'b0;
         flush        <= 1'b0;
      end
   end

   // Entry payload; validity is carried by busy/ready so no reset is needed.
   always_ff @(posedge clk) begin
      if (do_alloc) begin
         entry[tail] <= '{kind:    rob_kind_e'(issue_kind),
                          rd:      issue_rd,
                          pred_pc: issue_pred_pc,
                          value:   '0,
                          next_pc: '0};
      end
      if (rss_wr) begin
         entry[rss_idx].value   <= value_from_rss_bus;
         entry[rss_idx].next_pc <= next_pc_from_rss_bus;
      end
      if (lsb_wr) begin
         entry[lsb_idx].value <= value_from_lsb_bus;
      end
   end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer
Interface
REQ-001 SHALL have parameter ROB_SIZE, default 16, number of entries; ids 1..ROB_SIZE, id 0 = "none".
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rdy  input  1  global enable; low = hold all state and outputs.
REQ-005 SHALL have port issue_valid  input  1  issuer requests allocation this cycle.
REQ-006 SHALL have port issue_kind  input  2  0 reg-write, 1 branch, 2 store.
REQ-007 SHALL have port issue_rd  input  5  destination architectural register (0 = none).
REQ-008 SHALL have port issue_pred_pc  input  32  predicted next pc for branch.
REQ-009 SHALL have port dest_to_issuer  output  5  id the next allocation receives (tail index + 1).
REQ-010 SHALL have port is_ro_buffer_full  output  1  count == ROB_SIZE.
REQ-011 SHALL have port dest_from_rss_bus  input  5  ALU writeback id, 0 = idle.
REQ-012 SHALL have port value_from_rss_bus  input  32  ALU result.
REQ-013 SHALL have port next_pc_from_rss_bus  input  32  ALU-computed next pc.
REQ-014 SHALL have port dest_from_lsb_bus  input  5  load/store writeback id, 0 = idle.
REQ-015 SHALL have port value_from_lsb_bus  input  32  load data.
REQ-016 SHALL have port qj_id  input  5  operand-j lookup id.
REQ-017 SHALL have port qj_ready  output  1  entry qj_id has a value (combinational).
REQ-018 SHALL have port qj_value  output  32  value for qj_id.
REQ-019 SHALL have port qk_id  input  5  operand-k lookup id.
REQ-020 SHALL have port qk_ready  output  1  as qj_ready for qk_id.
REQ-021 SHALL have port qk_value  output  32  as qj_value for qk_id.
REQ-022 SHALL have port commit_valid  output  1  one-cycle pulse, head entry retired.
REQ-023 SHALL have port commit_kind  output  2  kind of retired entry.
REQ-024 SHALL have port commit_rd  output  5  register to write.
REQ-025 SHALL have port commit_value  output  32  value to write.
REQ-026 SHALL have port commit_dest  output  5  retired id, for clearing register tags / releasing store.
REQ-027 SHALL have port flush  output  1  one-cycle pulse, mispredict, pipeline clear.
REQ-028 SHALL have port flush_pc  output  32  redirect target.
Function
REQ-029 SHALL be circular: head, tail, count; allocate at tail when issue_valid && !full && !flush-cycle, ready bit cleared.
REQ-030 SHALL set ready/value/next_pc of entry dest_from_rss_bus and of entry dest_from_lsb_bus in the same edge when both nonzero (ids always differ).
REQ-031 SHALL forward lookups: qj_ready=1 if entry ready or qj_id equals a nonzero bus dest this cycle (lsb priority); id 0 returns ready=1, value 0.
REQ-032 SHALL retire at most one entry per cycle: head busy and ready -> registered commit outputs next cycle, head and count update.
REQ-033 SHALL, for branch at commit with next_pc != issue_pred_pc, assert commit and flush with flush_pc = next_pc, then clear all entries, head=tail=count=0.
REQ-034 SHALL permit allocate and commit same edge (count unchanged); full is registered state, so allocation refused when full even if commit frees an entry that edge.
REQ-035 SHALL wrap head/tail from ROB_SIZE-1 to 0; writeback to an empty entry ignored.
REQ-036 SHALL give latency: writeback at edge N, commit outputs valid during cycle after edge N+1.
REQ-037 SHALL drop allocation and writebacks in the flush edge.
REQ-038 SHALL, with rdy low, ignore all inputs and hold commit_valid/flush low.
REQ-039 SHALL drive commit_rd 0 for branch and store commits.
Reset
REQ-040 SHALL on rst low immediately clear all busy/ready bits, head, tail, count, commit_* and flush outputs, flush_pc to 0.
REQ-041 SHALL discard an in-progress allocation or commit when reset asserts mid-cycle.
Structure
REQ-042 SHALL take ROB id width, entry kinds and REG width from the shared config package.
REQ-043 SHALL be one flat module; no sub-module.
Verification
REQ-044 Issue 3 reg-writes, rss writeback ids 3,1,2 -> commits in order id 1,2,3, one per cycle.
REQ-045 Fill 16 entries -> full=1, 17th issue ignored; one commit -> full=0 next cycle, dest_to_issuer wraps to 1.
REQ-046 Branch pred 0x100, rss next_pc 0x104 -> flush=1, flush_pc=0x104, count=0 after.
REQ-047 qj_id=5 while dest_from_lsb_bus=5 value 0xDEAD -> qj_ready=1, qj_value=0xDEAD same cycle.
REQ-048 Assert rst low with 4 busy entries -> outputs 0 immediately, dest_to_issuer=1.
